// File: rtl/usr4_shift.sv
// ---------------------------------------------------------------------------
// usr4_shift : WIDTH-bit universal shift register.
//
// Modes, selected by SEL and applied at every rising CLK edge:
//   00 LOAD : the register takes D
//   01 S0in : contents move toward bit WIDTH-1, S0 enters bit 0
//   10 S3in : contents move toward bit 0, S3 enters bit WIDTH-1
//   11 HOLD : the register keeps its value
// Bits shifted out at either end are lost. The register does not rotate.
//
// Bit 0 is the leftmost bit (MSB). All vectors are declared [0:WIDTH-1],
// so a literal such as 4'b1010 puts a 1 in bit 0.
//
// RESET is synchronous and active-high. It clears the register and takes
// priority over every mode.
//
// Optional feature, controlled by the macro USR4_CLKEN_EN:
//   defined     : adds the CLKEN input. When CLKEN is 0 at a clock edge, the
//                 register holds regardless of SEL. RESET still clears it.
//   not defined : there is no CLKEN port, and the register behaves as if
//                 CLKEN were tied high.
// ---------------------------------------------------------------------------
module usr4_shift #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [0:1]       SEL,
  input  logic [0:WIDTH-1] D,
  input  logic             S0,
  input  logic             S3,
`ifdef USR4_CLKEN_EN
  input  logic             CLKEN,
`endif
  output logic [0:WIDTH-1] Q
);

  localparam logic [0:1] SEL_LOAD = 2'b00;
  localparam logic [0:1] SEL_S0IN = 2'b01;
  localparam logic [0:1] SEL_S3IN = 2'b10;
  localparam logic [0:1] SEL_HOLD = 2'b11;

  // Move every bit one place toward bit WIDTH-1 and bring s_in into bit 0.
  // The old bit WIDTH-1 drops off the end.
  function automatic logic [0:WIDTH-1] shift_from_s0(
    input logic [0:WIDTH-1] r,
    input logic             s_in
  );
    return {s_in, r[0:WIDTH-2]};
  endfunction

  // Move every bit one place toward bit 0 and bring s_in into bit WIDTH-1.
  // The old bit 0 drops off the end.
  function automatic logic [0:WIDTH-1] shift_from_s3(
    input logic [0:WIDTH-1] r,
    input logic             s_in
  );
    return {r[1:WIDTH-1], s_in};
  endfunction

  logic [0:WIDTH-1] r_q;
  logic [0:WIDTH-1] w_next;
  logic             w_en;

`ifdef USR4_CLKEN_EN
  assign w_en = CLKEN;
`else
  assign w_en = 1'b1;
`endif

  // Choose the register's next value from the selected mode.
  always_comb begin
    w_next = r_q;
    case (SEL)
      SEL_LOAD: w_next = D;
      SEL_S0IN: w_next = shift_from_s0(r_q, S0);
      SEL_S3IN: w_next = shift_from_s3(r_q, S3);
      SEL_HOLD: w_next = r_q;
      default:  w_next = r_q;
    endcase
  end

  // State register. Reset wins over the clock enable and over every mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q <= '0;
    end else if (w_en) begin
      r_q <= w_next;
    end
  end

  // Q comes straight from the register, with no combinational path from the inputs.
  assign Q = r_q;

endmodule

// File: tb/tb_usr4_shift.sv
// ---------------------------------------------------------------------------
// tb_usr4_shift : self-checking bench for usr4_shift (WIDTH = 4).
//
// The bench has three parts:
//   - a table of hand-derived vectors
//   - hand-written multi-cycle sequences
//   - random stimulus checked against an arithmetic reference model
//
// In the model, the register is held as an integer 0..15 with bit 0 as the
// MSB (value 8). An S0in shift is then a right shift by one with S0 entering
// at weight 8. An S3in shift is a left shift by one, truncated to 4 bits,
// with S3 entering at weight 1.
//
// Define USR4_CLKEN_EN for both the bench and the RTL to exercise CLKEN.
// ---------------------------------------------------------------------------
module tb_usr4_shift;

  logic       CLK;
  logic       RESET;
  logic [0:1] SEL;
  logic [0:3] D;
  logic       S0;
  logic       S3;
  logic       CLKEN;
  logic [0:3] Q;

  int n_tests = 0;
  int n_fail  = 0;
  int model   = 0;

  usr4_shift #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .SEL  (SEL),
    .D    (D),
    .S0   (S0),
    .S3   (S3),
`ifdef USR4_CLKEN_EN
    .CLKEN(CLKEN),
`endif
    .Q    (Q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit       rst;
    bit [1:0] sel;
    bit [3:0] d;
    bit       s0;
    bit       s3;
    bit       ce;
    bit [3:0] exp;
    string    name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit [1:0] sel, input bit [3:0] d,
                              input bit s0, input bit s3, input bit ce,
                              input bit [3:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.sel = sel; v.d = d; v.s0 = s0; v.s3 = s3; v.ce = ce;
    v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  // Reference model, computed directly from the mode rules with integer arithmetic.
  function automatic int model_next(input int m, input bit rst, input bit [1:0] sel,
                                    input bit [3:0] d, input bit s0, input bit s3,
                                    input bit ce);
    if (rst) return 0;
`ifdef USR4_CLKEN_EN
    if (!ce) return m;
`endif
    case (sel)
      2'b00:   return int'(d);
      2'b01:   return (int'(s0) * 8) + (m / 2);
      2'b10:   return ((m * 2) % 16) + int'(s3);
      default: return m;
    endcase
  endfunction

  // Drive inputs, then let exactly one rising edge pass and settle.
  task automatic apply(input bit rst, input bit [1:0] sel, input bit [3:0] d,
                       input bit s0, input bit s3, input bit ce);
    RESET = rst; SEL = sel; D = d; S0 = s0; S3 = s3; CLKEN = ce;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input bit [3:0] act, input bit [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Q=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; SEL = 2'b00; D = 4'b1111; S0 = 1'b0; S3 = 1'b0; CLKEN = 1'b1;

    // Vectors worked out by hand.
    add(1, 2'b00, 4'b1111, 0, 0, 1, 4'b0000, "reset");
    add(0, 2'b00, 4'b1010, 0, 0, 1, 4'b1010, "load_1010");
    add(0, 2'b11, 4'b0101, 1, 1, 1, 4'b1010, "hold_ignores_d");
    add(0, 2'b01, 4'b0000, 1, 0, 1, 4'b1101, "s0in_1");
    add(0, 2'b01, 4'b1111, 0, 1, 1, 4'b0110, "s0in_0");
    add(0, 2'b00, 4'b1010, 0, 0, 1, 4'b1010, "reload_1010");
    add(0, 2'b10, 4'b1111, 1, 0, 1, 4'b0100, "s3in_0");
    add(0, 2'b10, 4'b0000, 0, 1, 1, 4'b1001, "s3in_1");
    add(0, 2'b11, 4'b0000, 1, 0, 1, 4'b1001, "hold_1");
    add(0, 2'b11, 4'b1111, 0, 1, 1, 4'b1001, "hold_2");
    add(0, 2'b11, 4'b0110, 1, 1, 1, 4'b1001, "hold_3");
    add(1, 2'b01, 4'b1111, 1, 0, 1, 4'b0000, "reset_over_s0in");
    add(0, 2'b00, 4'b1111, 0, 0, 1, 4'b1111, "load_1111");
    add(0, 2'b01, 4'b0000, 0, 1, 1, 4'b0111, "s0_drop_1");
    add(0, 2'b01, 4'b0000, 0, 1, 1, 4'b0011, "s0_drop_2");
    add(0, 2'b01, 4'b0000, 0, 1, 1, 4'b0001, "s0_drop_3");
    add(0, 2'b01, 4'b0000, 0, 1, 1, 4'b0000, "s0_no_rotate");
    add(0, 2'b00, 4'b1111, 0, 0, 1, 4'b1111, "load_1111b");
    add(0, 2'b10, 4'b0000, 1, 0, 1, 4'b1110, "s3_drop_1");
    add(0, 2'b10, 4'b0000, 1, 0, 1, 4'b1100, "s3_drop_2");
    add(0, 2'b10, 4'b0000, 1, 0, 1, 4'b1000, "s3_drop_3");
    add(0, 2'b10, 4'b0000, 1, 0, 1, 4'b0000, "s3_no_rotate");
`ifdef USR4_CLKEN_EN
    add(0, 2'b00, 4'b1010, 0, 0, 1, 4'b1010, "ce_preload");
    add(0, 2'b00, 4'b0101, 0, 0, 0, 4'b1010, "ce_low_load");
    add(0, 2'b01, 4'b0101, 1, 0, 0, 4'b1010, "ce_low_shift");
    add(0, 2'b00, 4'b0101, 0, 0, 1, 4'b0101, "ce_high_load");
    add(1, 2'b00, 4'b1111, 0, 0, 0, 4'b0000, "reset_over_ce_low");
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].sel, tbl[i].d, tbl[i].s0, tbl[i].s3, tbl[i].ce);
      check(tbl[i].name, Q, tbl[i].exp);
    end

    // Reset in the middle of a load/shift sequence discards the pending operation.
    apply(0, 2'b00, 4'b0110, 0, 0, 1);
    check("seq_load_0110", Q, 4'b0110);
    apply(1, 2'b00, 4'b1001, 0, 0, 1);
    check("seq_reset_drops_load", Q, 4'b0000);
    apply(0, 2'b01, 4'b0000, 1, 0, 1);
    check("seq_shift_after_reset", Q, 4'b1000);

    // Only the value of D present at the clock edge is loaded; earlier changes have no effect.
    RESET = 1'b0; SEL = 2'b00; CLKEN = 1'b1; D = 4'b0000;
    #2 D = 4'b1111;
    #1 D = 4'b0110;
    @(posedge CLK);
    #1;
    check("glitch_d_sampled_at_edge", Q, 4'b0110);

    // Random stimulus checked against the reference model.
    model = 6;
    for (int i = 0; i < 400; i++) begin
      bit       r_rst;
      bit [1:0] r_sel;
      bit [3:0] r_d;
      bit       r_s0, r_s3, r_ce;
      r_rst = ($urandom_range(0, 15) == 0);
      r_sel = 2'($urandom_range(0, 3));
      r_d   = 4'($urandom_range(0, 15));
      r_s0  = 1'($urandom_range(0, 1));
      r_s3  = 1'($urandom_range(0, 1));
      r_ce  = ($urandom_range(0, 3) != 0);
      apply(r_rst, r_sel, r_d, r_s0, r_s3, r_ce);
      model = model_next(model, r_rst, r_sel, r_d, r_s0, r_s3, r_ce);
      check($sformatf("rand_%0d", i), Q, 4'(model));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
